cpu_icache: RTL
===============

// Module: cpu_icache
// PURPOSE
//  Direct-mapped instruction cache; the responder to the fetch stage's lookup interface.
//  Answers the X and Y lookups combinationally with a hit flag and a word.
//  On an X miss it refills one 4-byte line from the byte-wide memory port, using a refill FSM.
//  Sits between fetch and the memory arbiter.
// PARAMETERS
//  ADDR_W     32  address width
//  INDEX_BITS 7   log2(lines); each line is one 32-bit word; tag = addr[ADDR_W-1:INDEX_BITS+2]
// PORTS
//  clk       in   1       clock; all state updates on posedge
//  rst       in   1       synchronous, active-high reset
//  rdy       in   1       global enable; low freezes FSM and issue counter
//  en_rx     in   1       X lookup request; may start a refill
//  pcx       in   ADDR_W  X address; bits [1:0] ignored
//  en_ry     in   1       Y lookup request; lookup only, never starts a refill
//  pcy       in   ADDR_W  Y address; bits [1:0] ignored
//  hitx      out  1       X hit, combinational
//  instx     out  32      X word, combinational; 0 when !hitx
//  hity      out  1       Y hit, combinational
//  insty     out  32      Y word, combinational; 0 when !hity
//  mem_en    out  1       byte read request
//  mem_addr  out  ADDR_W  byte address of the request
//  mem_gnt   in   1       arbiter accepts the request this cycle
//  mem_din   in   8       read byte, valid the cycle after an accepted request
// BEHAVIOUR
//  Lookup and reset
//  - hitx = en_rx & valid[idx] & tag match; hity likewise with en_ry/pcy. Pure combinational read.
//  - Word packing: byte at the lowest address goes in [31:24].
//    instx = {M[a], M[a+1], M[a+2], M[a+3]}, matching the byte reversal done in fetch.
//  - Reset: all valid bits 0, FSM=IDLE, mem_en=0, mem_addr=0, counters 0.
//    Therefore hitx/hity=0 and instx/insty=0. An in-flight byte is discarded.
//  FSM IDLE -> REQ
//  - Condition: rdy & en_rx & !hitx at a posedge.
//  - Latch miss_addr={pcx[ADDR_W-1:2],2'b00}; clear valid[miss idx]; issue=0, recv=0.
//  FSM REQ
//  - mem_en = rdy & (issue<4); mem_addr = miss_addr + issue.
//  - issue increments on each posedge where mem_en & mem_gnt.
//  - The byte for every accepted request is captured from mem_din at the next posedge, even if rdy is low then.
//    It goes to byte lane recv, then recv increments.
//  - When recv reaches 4: write data+tag, set valid, go to IDLE, all on the same edge.
//  - Latency with mem_gnt held 1: miss latched at edge E0; requests in the cycles after E0..E3.
//    The line is written at E5. hitx rises in the cycle after E5.
//  - mem_gnt=0 stalls issue only; the address is held stable until it is accepted.
//  Boundaries
//  - pcx changes during a refill (jump/branch redirect): the refill still completes for miss_addr.
//    A miss on the new pcx is then detected from IDLE.
//  - Lookups to other indices hit normally during a refill. The line being refilled reads as miss until written.
//  - en_rx=0 or a hit in IDLE: no memory traffic.
//  - Y port: a Y miss never refills; it waits for fetch to retry through X.
//  - Conflict miss: a new tag overwrites the line. No write path, no flush. Code is read-only.
//  - rdy low in REQ: mem_en=0 and the FSM holds; bytes already accepted are still captured.
//  - rst during REQ: everything returns to reset state at that edge.
// TESTING
//  1 Reset, then en_rx=1, pcx=0x0, mem_gnt=1, M[0..3]=13 00 00 93.
//    -> mem_addr 0,1,2,3 on consecutive cycles. hitx=1 and instx=0x13000093 the cycle after E5.
//  2 After test 1, pcx=0x0 again, and en_ry=1 with pcy=0x0.
//    -> hitx=hity=1 and mem_en=0 throughout.
//  3 pcx=0x200 (same index as 0x0 when INDEX_BITS=7).
//    -> refill from 0x200..0x203; afterwards 0x0 misses and 0x200 hits.
//  4 Miss at 0x4 with mem_gnt toggling 1,0,1,0,...
//    -> each address is held while gnt=0; exactly 4 accepts; correct word.
//  5 Miss at 0x8; pcx switches to 0x40 two cycles later.
//    -> 0x8 line completes; then refill of 0x40 starts; both hit afterwards.
//  6 rst asserted mid-refill, and rdy=0 for 3 cycles mid-refill (separate runs).
//    -> reset run: all hits 0, mem_en=0 next cycle.
//    -> rdy run: FSM frozen during rdy=0; line still correct after rdy=1.

Source files
------------

// File: rtl/cpu_icache.sv
// Direct-mapped, one-word-per-line instruction cache serving the fetch stage's X/Y lookups.
// X misses refill the line one byte at a time from the byte-wide memory port.
module cpu_icache #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              en_rx,
  input  logic [ADDR_W-1:0] pcx,
  input  logic              en_ry,
  input  logic [ADDR_W-1:0] pcy,
  output logic              hitx,
  output logic [31:0]       instx,
  output logic              hity,
  output logic [31:0]       insty,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_din
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [0:0]            state;
  logic [2:0]            issue;
  logic [2:0]            recv;
  logic [ADDR_W-1:0]     miss_addr;
  logic                  pending;
  logic [31:0]           line_buf;

  logic [INDEX_BITS-1:0] idx_x, idx_y, miss_idx;
  logic [TAG_W-1:0]      tag_x, tag_y;
  logic                  last_byte;
  logic                  done;
  logic [31:0]           fill_word;

  assign idx_x    = pcx[INDEX_BITS+1:2];
  assign idx_y    = pcy[INDEX_BITS+1:2];
  assign tag_x    = pcx[ADDR_W-1:INDEX_BITS+2];
  assign tag_y    = pcy[ADDR_W-1:INDEX_BITS+2];
  assign miss_idx = miss_addr[INDEX_BITS+1:2];

  assign hitx  = en_rx & valid[idx_x] & (tag_mem[idx_x] == tag_x);
  assign hity  = en_ry & valid[idx_y] & (tag_mem[idx_y] == tag_y);
  assign instx = hitx ? data_mem[idx_x] : 32'd0;
  assign insty = hity ? data_mem[idx_y] : 32'd0;

  assign mem_en   = (state == REQ) & rdy & ~issue[2];
  assign mem_addr = (state == REQ) ? miss_addr + ADDR_W'(issue) : '0;

  // The line completes on the edge that captures its fourth byte; if rdy was low
  // then, recv parks at 4 and the write happens once rdy returns.
  assign last_byte = pending & (recv == 3'd3);
  assign done      = (state == REQ) & rdy & (last_byte | recv[2]);
  assign fill_word = recv[2] ? line_buf : {line_buf[31:8], mem_din};

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      issue     <= '0;
      recv      <= '0;
      miss_addr <= '0;
      pending   <= 1'b0;
      line_buf  <= '0;
    end else begin
      pending <= mem_en & mem_gnt;

      // Byte lane recv: lane 0 (lowest address) lands in [31:24].
      if (pending && !recv[2]) begin
        line_buf[{~recv[1:0], 3'b000} +: 8] <= mem_din;
        recv <= recv + 3'd1;
      end

      case (state)
        IDLE: begin
          if (rdy && en_rx && !hitx) begin
            state        <= REQ;
            miss_addr    <= {pcx[ADDR_W-1:2], 2'b00};
            valid[idx_x] <= 1'b0;
            issue        <= '0;
            recv         <= '0;
          end
        end
        REQ: begin
          if (mem_en && mem_gnt) issue <= issue + 3'd1;
          if (done) begin
            state           <= IDLE;
            valid[miss_idx] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether they are read.
  always_ff @(posedge clk) begin
    if (!rst && done) begin
      data_mem[miss_idx] <= fill_word;
      tag_mem[miss_idx]  <= miss_addr[ADDR_W-1:INDEX_BITS+2];
    end
  end

endmodule
